// File: rtl/shuma_capture_if.sv
// Scanned 7-segment bus as seen by the capture block, plus its decoded results.
// The display driver side uses master; the capture block uses slave.
interface shuma_capture_if #(
  parameter int DIGITS = 4
);
  logic                  a, b, c, d, e, f, g;
  logic [DIGITS-1:0]     sel;
  logic                  sample_en;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     blank;
  logic [DIGITS-1:0]     err;
  logic [DIGITS-1:0]     upd;
  logic                  sel_err;
  logic                  frame_ok;

  modport master (
    output a, b, c, d, e, f, g, sel, sample_en,
    input  data, blank, err, upd, sel_err, frame_ok
  );

  modport slave (
    input  a, b, c, d, e, f, g, sel, sample_en,
    output data, blank, err, upd, sel_err, frame_ok
  );
endinterface

// File: rtl/shuma_capture.sv
// Readback of a scanned 7-segment display: decodes each digit back to BCD and
// commits it only after STABLE_CNT consecutive identical samples.
module shuma_capture #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic           clk,
  input  logic           rst,
  shuma_capture_if.slave bus
);

  // CL_NONE only exists after reset so the first real sample never matches.
  typedef enum logic [1:0] {
    CL_NONE    = 2'd0,
    CL_DIGIT   = 2'd1,
    CL_BLANK   = 2'd2,
    CL_INVALID = 2'd3
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic [3:0] code;
  } cand_t;

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT - 1);

  logic [6:0]        pat;
  cand_t             cur;
  logic              sel_ok;

  cand_t             cand    [DIGITS];
  logic [3:0]        cnt     [DIGITS];
  logic [3:0]        nxt_cnt [DIGITS];
  logic [DIGITS-1:0] seen;
  logic [DIGITS-1:0] take, same, commit, changed;

  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   blank_q, err_q, upd_q;
  logic                sel_err_q, frame_ok_q;

  assign pat    = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};
  assign sel_ok = $onehot(bus.sel);

  // NOTE: every output of a combinational block gets a default before the
  // case, otherwise unlisted patterns would infer a latch.
  always_comb begin
    cur.cls  = CL_DIGIT;
    cur.code = 4'd0;
    case (pat)
      7'b1111110: cur.code = 4'd0;
      7'b0110000: cur.code = 4'd1;
      7'b1101101: cur.code = 4'd2;
      7'b1111001: cur.code = 4'd3;
      7'b0110011: cur.code = 4'd4;
      7'b1011011: cur.code = 4'd5;
      7'b1011111: cur.code = 4'd6;
      7'b1110000: cur.code = 4'd7;
      7'b1111111: cur.code = 4'd8;
      7'b1111011: cur.code = 4'd9;
      7'b0000000: cur.cls  = CL_BLANK;
      default:    cur.cls  = CL_INVALID;
    endcase
  end

  // Commit happens on the sample that brings the run length to STABLE_CNT;
  // the counter then saturates so repeats re-commit silently.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      take[i]    = bus.sample_en & sel_ok & bus.sel[i];
      same[i]    = (cand[i] == cur);
      nxt_cnt[i] = !same[i] ? 4'd0 :
                   (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + 4'd1;
      commit[i]  = take[i] & (nxt_cnt[i] == CNT_MAX);
      changed[i] = !seen[i]
                 || (data_q[4*i +: 4] != cur.code)
                 || (blank_q[i] != (cur.cls == CL_BLANK))
                 || (err_q[i]   != (cur.cls == CL_INVALID));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-digit candidate/counter arrays are reset too, because a
      // stale candidate would shorten the first commit after reset.
      for (int i = 0; i < DIGITS; i++) begin
        cand[i] <= '{cls: CL_NONE, code: 4'd0};
        cnt[i]  <= 4'd0;
      end
      seen       <= '0;
      data_q     <= '0;
      blank_q    <= '1;
      err_q      <= '0;
      upd_q      <= '0;
      sel_err_q  <= 1'b0;
      frame_ok_q <= 1'b0;
    end else begin
      sel_err_q  <= bus.sample_en & ~sel_ok;
      frame_ok_q <= frame_ok_q | (&seen);
      for (int i = 0; i < DIGITS; i++) begin
        upd_q[i] <= commit[i] & changed[i];
        if (take[i]) begin
          cand[i] <= cur;
          cnt[i]  <= nxt_cnt[i];
        end
        if (commit[i]) begin
          data_q[4*i +: 4] <= cur.code;
          blank_q[i]       <= (cur.cls == CL_BLANK);
          err_q[i]         <= (cur.cls == CL_INVALID);
          seen[i]          <= 1'b1;
        end
      end
    end
  end

  assign bus.data     = data_q;
  assign bus.blank    = blank_q;
  assign bus.err      = err_q;
  assign bus.upd      = upd_q;
  assign bus.sel_err  = sel_err_q;
  assign bus.frame_ok = frame_ok_q;

endmodule
